// File: rtl/load_store_ctrl.sv
// load_store_ctrl: sequences one byte/half/word access to the data memory port,
// drives word-aligned requests with byte enables, waits for an ack or a timeout,
// and returns lane-selected, zero/sign-extended load data.
module load_store_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [1:0]       r_lane;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_wdata;
  logic             r_resp_valid;
  logic [31:0]      r_resp_rdata;
  logic             r_resp_err;

  logic             w_bad;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;
  logic [31:0]      w_load;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_mem_req_nxt;
  logic             w_resp_valid_nxt;
  logic [31:0]      w_resp_rdata_nxt;
  logic             w_resp_err_nxt;
  logic             w_issue;

  // Decode incoming request: legality, byte enables, lane-replicated store data
  always_comb begin
    w_bad   = 1'b0;
    w_be    = 4'b0000;
    w_wdata = req_wdata;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_bad   = req_addr[0];
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_bad = (req_addr[1:0] != 2'b00);
        w_be  = 4'b1111;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Select the addressed lane of the read word and extend it to 32 bits
  always_comb begin
    w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
    w_load = r_mem_we ? 32'h0 : w_ext;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_mem_req_nxt    = r_mem_req;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_issue          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_bad) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = 32'h0;
          end else begin
            w_issue       = 1'b1;
            w_state_nxt   = S_ACCESS;
            w_cnt_nxt     = '0;
            w_mem_req_nxt = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          w_state_nxt      = S_RESP;
          w_mem_req_nxt    = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = w_load;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          w_state_nxt      = S_RESP;
          w_mem_req_nxt    = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b1;
          w_resp_rdata_nxt = 32'h0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; request fields latched on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      if (w_issue) begin
        r_size      <= req_size;
        r_signed    <= req_signed;
        r_lane      <= req_addr[1:0];
        r_mem_we    <= req_we;
        r_mem_addr  <= {req_addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: directed vector table, reset-mid-access sequence,
// and randomized transactions checked against a behavioural model.
module tb_load_store_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  load_store_ctrl #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack;   // cycle of the ack after acceptance, 0 = never
    logic [3:0]  be;
    logic [31:0] mw;
    logic [31:0] rd;
    logic        err;
    int          lat;   // cycle in which resp_valid is expected
  } vec_t;

  int errors = 0;
  int checks = 0;

  int          o_resp_cyc;
  int          o_req_cyc;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [31:0] o_rdata;
  logic [3:0]  o_be;
  logic        o_we;
  logic        o_err;
  logic        o_unstable;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: address/size rules computed arithmetically
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic bad,
                                output logic [3:0] be, output logic [31:0] mw,
                                output logic [31:0] rd);
    int n;
    int off;
    longint unsigned mask;
    longint unsigned v;
    longint unsigned w;
    off  = int'(addr[1:0]);
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    bad  = (size == 2'd3) || ((off % n) != 0);
    be   = 4'(((1 << n) - 1) << off);
    mask = (64'd1 << (8 * n)) - 64'd1;
    w    = 64'(wdata) & mask;
    v    = 64'd0;
    for (int i = 0; i < 4 / n; i++) v = v | (w << (8 * n * i));
    mw   = 32'(v);
    v    = (64'(rdata) >> (8 * off)) & mask;
    if (sgn && n < 4 && v[8 * n - 1]) v = v | ~mask;
    rd   = we ? 32'h0 : 32'(v);
  endfunction

  // Issue one request and observe the memory side and the response
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_cyc);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_ack    = 1'b0;
    o_resp_cyc = -1;
    o_req_cyc  = 0;
    o_unstable = 1'b0;
    o_rdata    = 32'h0;
    o_err      = 1'b0;
    o_addr     = 32'h0;
    o_wdata    = 32'h0;
    o_be       = 4'h0;
    o_we       = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (mem_req) begin
        if (o_req_cyc == 0) begin
          o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_be !== o_be ||
                     mem_wdata !== o_wdata || mem_we !== o_we) begin
          o_unstable = 1'b1;
        end
        o_req_cyc++;
      end
      mem_ack   = (c == ack_cyc);
      mem_rdata = (c == ack_cyc) ? rdata : $urandom;
      if (resp_valid) begin
        o_resp_cyc = c;
        o_rdata    = resp_rdata;
        o_err      = resp_err;
        req_valid  = 1'b0;
        break;
      end
      // Unrelated traffic on the request lines while busy must not be taken
      req_valid  = 1'($urandom);
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    req_valid = 1'b0;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic verify(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] mw, input logic [31:0] rd,
                        input logic err, input int lat);
    chk({tag, "_latency"}, 32'(o_resp_cyc), 32'(lat));
    chk({tag, "_req_cycles"}, 32'(o_req_cyc), 32'(lat - 1));
    chk({tag, "_err"}, 32'(o_err), 32'(err));
    chk({tag, "_rdata"}, o_rdata, rd);
    chk({tag, "_pulse_len"}, 32'(resp_valid), 32'(0));
    chk({tag, "_ready_after"}, 32'(req_ready), 32'(1));
    if (lat > 1) begin
      chk({tag, "_addr"}, o_addr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, 32'(o_be), 32'(be));
      chk({tag, "_wdata"}, o_wdata, mw);
      chk({tag, "_we"}, 32'(o_we), 32'(we));
      chk({tag, "_stable"}, 32'(o_unstable), 32'(0));
    end
  endtask

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'h8012_3456, 2, 4'h8, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 3};
    tbl[1]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_0000, 32'h8001_1234, 1, 4'hC, 32'h0000_0000, 32'h0000_8001, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'h5555_5555, 1, 4'h2, 32'hABAB_ABAB, 32'h0000_0000, 1'b0, 2};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h1111_1111, 1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h1111_1111, 0, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, 5};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 4, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 5};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h1234_F00D, 3, 4'h3, 32'h0000_0000, 32'hFFFF_F00D, 1'b0, 4};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_5678, 32'hFFFF_FFFF, 1, 4'hC, 32'h5678_5678, 32'h0000_0000, 1'b0, 2};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h1122_3344, 32'h00AB_0000, 2, 4'h4, 32'h4444_4444, 32'h0000_00AB, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd2, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h8000_0000, 1, 4'hF, 32'h0000_0000, 32'h8000_0000, 1'b0, 2};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h1234_5678, 5, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, 5};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_000C, 32'hCAFE_F00D, 32'h0000_0000, 4, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 5};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_7F00, 1, 4'h2, 32'h0000_0000, 32'h0000_007F, 1'b0, 2};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) step();
    rst = 1'b0;

    // Reset values
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mem_req", 32'(mem_req), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_err", 32'(resp_err), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'(0));
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    // Directed vectors, issued back to back
    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
              tbl[i].rdata, tbl[i].ack);
      verify($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].mw,
             tbl[i].rd, tbl[i].err, tbl[i].lat);
    end

    // Reset in the middle of an access, then a stray ack
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_0040; mem_ack = 1'b0;
    step();
    req_valid = 1'b0;
    chk("midrst_req_c1", 32'(mem_req), 32'(1));
    chk("midrst_busy_c1", 32'(busy), 32'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    chk("midrst_req_c3", 32'(mem_req), 32'(0));
    chk("midrst_resp_c3", 32'(resp_valid), 32'(0));
    chk("midrst_ready_c3", 32'(req_ready), 32'(1));
    chk("midrst_busy_c3", 32'(busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_noresp%0d", i), 32'(resp_valid), 32'(0));
      chk($sformatf("midrst_noreq%0d", i), 32'(mem_req), 32'(0));
    end
    mem_ack = 1'b0;
    run_txn(tbl[0].we, tbl[0].size, tbl[0].sgn, tbl[0].addr, tbl[0].wdata,
            tbl[0].rdata, tbl[0].ack);
    verify("post_rst", tbl[0].addr, tbl[0].we, tbl[0].be, tbl[0].mw, tbl[0].rd,
           tbl[0].err, tbl[0].lat);

    // Randomized transactions against the model
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdv;
      int          ack;
      logic        bad;
      logic [3:0]  be;
      logic [31:0] mw;
      logic [31:0] rd;
      int          lat;
      we   = 1'($urandom);
      size = 2'($urandom);
      sgn  = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(1, 0) == 1 && size != 2'd0) addr[1:0] = (size == 2'd1) ? {addr[1], 1'b0} : 2'b00;
      wd   = $urandom;
      rdv  = $urandom;
      ack  = $urandom_range(6, 0);
      model(we, size, sgn, addr, wd, rdv, bad, be, mw, rd);
      if (bad) begin
        lat = 1;
        rd  = 32'h0;
      end else if (ack >= 1 && ack <= int'(T)) begin
        lat = ack + 1;
      end else begin
        lat = int'(T) + 1;
        rd  = 32'h0;
      end
      run_txn(we, size, sgn, addr, wd, rdv, ack);
      verify($sformatf("rnd%0d", n), addr, we, be, mw, rd,
             bad || !(ack >= 1 && ack <= int'(T)), lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
